// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file sequencer: opcodes,
// instruction field positions, FSM states and the decoded-opcode bundle.
package regfile_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int DST_MSB  = 11;
    localparam int DST_LSB  = 8;
    localparam int SRCA_MSB = 7;
    localparam int SRCA_LSB = 4;
    localparam int SRCB_MSB = 3;
    localparam int SRCB_LSB = 0;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        EXEC    = 3'd3,
        WRITE   = 3'd4,
        HALTED  = 3'd5
    } state_t;

    typedef struct packed {
        logic       isNop;
        logic       isAlu;
        logic       isMov;
        logic       isHalt;
        logic [2:0] aluOp;
    } decode_t;

endpackage

// File: rtl/rfc_decode.sv
// Combinational opcode classifier; unassigned opcodes fall into the NOP class.
module rfc_decode
    import regfile_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output decode_t    dec
);

    always_comb begin
        dec       = '0;
        dec.aluOp = opcode[2:0];
        if (opcode == OP_MOV) begin
            dec.isMov = 1'b1;
        end else if (opcode == OP_HALT) begin
            dec.isHalt = 1'b1;
        end else if (!opcode[3] && opcode != OP_NOP) begin
            dec.isAlu = 1'b1;
        end else begin
            dec.isNop = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Instruction sequencer driving register-file reads/write-back and the ALU handshake.
// Optional performance counters (retired/aborted) are built when RFC_PERF_CNT_EN is defined.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  rf_aaddr,
    output logic [3:0]  rf_baddr,
    output logic [3:0]  rf_caddr,
    output logic [15:0] rf_c,
    output logic        rf_load,
    input  logic [15:0] rf_a,
    input  logic [15:0] rf_b,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_opa,
    output logic [15:0] alu_opb,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        err,
`ifdef RFC_PERF_CNT_EN
    output logic [15:0] retired,
    output logic [7:0]  aborted,
`endif
    output logic        halted
);

    localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT);

    state_t      state_reg;
    decode_t     dec;
    logic [2:0]  aluOp_reg;
    logic        isMov_reg;
    logic [3:0]  dest_reg;
    logic [3:0]  srcA_reg;
    logic [3:0]  srcB_reg;
    logic [15:0] opa_reg;
    logic [15:0] opb_reg;
    logic [15:0] rfC_reg;
    logic [4:0]  waitCnt_reg;
    logic        accept;
    logic        execDone;
    logic        timeout;

    rfc_decode u_decode (
        .opcode (instr[OPC_MSB:OPC_LSB]),
        .dec    (dec)
    );

    assign instr_ready = (state_reg == IDLE) && !clear;
    assign accept      = instr_valid && instr_ready;
    // waitCnt_reg is zero in the start cycle, so done is only honoured from the next one
    assign execDone    = (state_reg == EXEC) && (waitCnt_reg != 5'd0) && alu_done;
    assign timeout     = (state_reg == EXEC) && (waitCnt_reg == TIMEOUT_CNT) && !alu_done;

    // Strobes are masked by clear so an aborted access never reaches the ports
    assign rf_load   = ((state_reg == READ) || (state_reg == WRITE)) && !clear;
    assign alu_start = (state_reg == EXEC) && (waitCnt_reg == 5'd0) && !clear;
    assign err       = timeout && !clear;
    assign halted    = (state_reg == HALTED);

    assign rf_aaddr = srcA_reg;
    assign rf_baddr = srcB_reg;
    assign rf_caddr = dest_reg;
    assign rf_c     = rfC_reg;
    assign alu_op   = aluOp_reg;
    assign alu_opa  = opa_reg;
    assign alu_opb  = opb_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg   <= IDLE;
            aluOp_reg   <= 3'd0;
            isMov_reg   <= 1'b0;
            dest_reg    <= 4'd0;
            srcA_reg    <= 4'd0;
            srcB_reg    <= 4'd0;
            opa_reg     <= 16'd0;
            opb_reg     <= 16'd0;
            rfC_reg     <= 16'd0;
            waitCnt_reg <= 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        aluOp_reg <= dec.aluOp;
                        isMov_reg <= dec.isMov;
                        dest_reg  <= instr[DST_MSB:DST_LSB];
                        srcA_reg  <= instr[SRCA_MSB:SRCA_LSB];
                        srcB_reg  <= instr[SRCB_MSB:SRCB_LSB];
                        if (dec.isHalt) begin
                            state_reg <= HALTED;
                        end else if (dec.isNop) begin
                            state_reg <= IDLE;
                        end else if (dec.isAlu || dec.isMov) begin
                            state_reg <= READ;
                        end
                    end
                end
                READ: state_reg <= CAPTURE;
                CAPTURE: begin
                    opa_reg     <= rf_a;
                    opb_reg     <= rf_b;
                    waitCnt_reg <= 5'd0;
                    if (isMov_reg) begin
                        rfC_reg   <= rf_a;
                        state_reg <= WRITE;
                    end else begin
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (execDone) begin
                        rfC_reg   <= alu_result;
                        state_reg <= WRITE;
                    end else if (timeout) begin
                        state_reg <= IDLE;
                    end else begin
                        waitCnt_reg <= waitCnt_reg + 5'd1;
                    end
                end
                WRITE:   state_reg <= IDLE;
                HALTED:  state_reg <= HALTED;
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef RFC_PERF_CNT_EN
    logic [15:0] retired_reg;
    logic [7:0]  aborted_reg;

    assign retired = retired_reg;
    assign aborted = aborted_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            retired_reg <= 16'd0;
            aborted_reg <= 8'd0;
        end else begin
            if ((state_reg == WRITE) || (accept && (dec.isNop || dec.isHalt))) begin
                retired_reg <= retired_reg + 16'd1;
            end
            if (timeout && (aborted_reg != 8'hFF)) begin
                aborted_reg <= aborted_reg + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench: a cycle timeline is planned from the instruction timing rules,
// then replayed against the DUT with every output compared each cycle.
module tb_regfile_ctrl;

    localparam int NC      = 3000;
    localparam int TMO     = 16;
    localparam int K_NOP   = 0;
    localparam int K_ALU   = 1;
    localparam int K_MOV   = 2;
    localparam int K_HALT  = 3;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] instr = 16'd0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  rf_aaddr, rf_baddr, rf_caddr;
    logic [15:0] rf_c;
    logic        rf_load;
    logic [15:0] rf_a = 16'd0;
    logic [15:0] rf_b = 16'd0;
    logic [2:0]  alu_op;
    logic [15:0] alu_opa, alu_opb;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'd0;
    logic        err;
    logic        halted;
`ifdef RFC_PERF_CNT_EN
    logic [15:0] retired;
    logic [7:0]  aborted;
`endif

    regfile_ctrl #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .clear       (clear),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rf_aaddr    (rf_aaddr),
        .rf_baddr    (rf_baddr),
        .rf_caddr    (rf_caddr),
        .rf_c        (rf_c),
        .rf_load     (rf_load),
        .rf_a        (rf_a),
        .rf_b        (rf_b),
        .alu_op      (alu_op),
        .alu_opa     (alu_opa),
        .alu_opb     (alu_opb),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .err         (err),
`ifdef RFC_PERF_CNT_EN
        .retired     (retired),
        .aborted     (aborted),
`endif
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Planned stimulus per cycle
    logic        vClear [NC];
    logic        vValid [NC];
    logic [15:0] vInstr [NC];
    logic [15:0] vRfA   [NC];
    logic [15:0] vRfB   [NC];
    logic        vDone  [NC];
    logic [15:0] vRes   [NC];
    // Expected outputs per cycle
    logic        eReady [NC];
    logic        eLoad  [NC];
    logic        eStart [NC];
    logic        eErr   [NC];
    logic        eHalted[NC];
    logic        chkRd  [NC];
    logic        chkWr  [NC];
    logic [3:0]  eA     [NC];
    logic [3:0]  eB     [NC];
    logic [3:0]  eCa    [NC];
    logic [15:0] eC     [NC];
    logic [15:0] eOpa   [NC];
    logic [15:0] eOpb   [NC];
    logic [2:0]  eOp    [NC];
    logic        evRet  [NC];
    logic        evAbt  [NC];

    int  t;
    bit  hb;
    int  tEnd;
    int  nChecks = 0;
    int  nFail   = 0;
    int  addT0, movT0, toT0, exT0, clrT0, haltT0, postClrT, perfRetT, perfAbtT;

    function automatic int kindOf(input logic [3:0] op);
        if (op == 4'hF) return K_HALT;
        if (op == 4'h8) return K_MOV;
        if (op >= 4'h1 && op <= 4'h7) return K_ALU;
        return K_NOP;
    endfunction

    task automatic noise(input int c);
        vValid[c] = 1'($urandom);
        vInstr[c] = 16'($urandom);
        vDone[c]  = 1'($urandom);
        vRes[c]   = 16'($urandom);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            eReady[t]  = !hb;
            eHalted[t] = hb;
            vDone[t]   = 1'($urandom);
            if (hb) begin
                vValid[t] = 1'($urandom);
                vInstr[t] = 16'($urandom);
            end
            t++;
        end
    endtask

    task automatic schedWrite(input int c, input logic [3:0] addr, input logic [15:0] data);
        eLoad[c] = 1'b1;
        chkWr[c] = 1'b1;
        eCa[c]   = addr;
        eC[c]    = data;
        evRet[c] = 1'b1;
    endtask

    // d = ALU done delay in cycles after start (1..TMO), 0 = ALU never answers
    task automatic issue(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b,
                         input int d, input logic [15:0] res);
        int t0;
        int k;
        int tNext;
        t0 = t;
        k  = kindOf(ins[15:12]);
        vValid[t0] = 1'b1;
        vInstr[t0] = ins;
        eReady[t0] = 1'b1;
        if (k == K_NOP || k == K_HALT) begin
            evRet[t0] = 1'b1;
            t = t0 + 1;
            if (k == K_HALT) hb = 1'b1;
        end else begin
            if (k == K_MOV) tNext = t0 + 4;
            else if (d >= 1 && d <= TMO) tNext = t0 + 5 + d;
            else tNext = t0 + 4 + TMO;
            for (int c = t0 + 1; c < tNext; c++) noise(c);
            eLoad[t0+1] = 1'b1;
            chkRd[t0+1] = 1'b1;
            eA[t0+1]    = ins[7:4];
            eB[t0+1]    = ins[3:0];
            vRfA[t0+2]  = a;
            vRfB[t0+2]  = b;
            if (k == K_MOV) begin
                schedWrite(t0 + 3, ins[11:8], a);
            end else begin
                eStart[t0+3] = 1'b1;
                eOpa[t0+3]   = a;
                eOpb[t0+3]   = b;
                eOp[t0+3]    = ins[14:12];
                if (d >= 1 && d <= TMO) begin
                    for (int c = t0 + 4; c < t0 + 3 + d; c++) vDone[c] = 1'b0;
                    vDone[t0+3+d] = 1'b1;
                    vRes[t0+3+d]  = res;
                    schedWrite(t0 + 4 + d, ins[11:8], res);
                end else begin
                    for (int c = t0 + 4; c <= t0 + 3 + TMO; c++) vDone[c] = 1'b0;
                    eErr[t0+3+TMO]  = 1'b1;
                    evAbt[t0+3+TMO] = 1'b1;
                end
            end
            t = tNext;
        end
    endtask

    task automatic clearNow();
        vClear[t]  = 1'b1;
        vValid[t]  = 1'b0;
        eReady[t]  = 1'b0;
        eHalted[t] = hb;
        hb = 1'b0;
        t++;
    endtask

    // Cut the already planned operation short with a clear in cycle tc
    task automatic clearAt(input int tc);
        for (int c = tc; c < t; c++) begin
            vValid[c] = 1'b0; vDone[c] = 1'b0;
            eReady[c] = 1'b0; eLoad[c] = 1'b0; eStart[c] = 1'b0; eErr[c] = 1'b0;
            eHalted[c] = 1'b0; chkRd[c] = 1'b0; chkWr[c] = 1'b0;
            evRet[c] = 1'b0; evAbt[c] = 1'b0;
        end
        t = tc;
        clearNow();
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic plan();
        for (int c = 0; c < NC; c++) begin
            vClear[c] = 1'b0; vValid[c] = 1'b0; vInstr[c] = 16'd0;
            vRfA[c] = 16'($urandom); vRfB[c] = 16'($urandom);
            vDone[c] = 1'b0; vRes[c] = 16'($urandom);
            eReady[c] = 1'b0; eLoad[c] = 1'b0; eStart[c] = 1'b0; eErr[c] = 1'b0;
            eHalted[c] = 1'b0; chkRd[c] = 1'b0; chkWr[c] = 1'b0;
            eA[c] = 4'd0; eB[c] = 4'd0; eCa[c] = 4'd0; eC[c] = 16'd0;
            eOpa[c] = 16'd0; eOpb[c] = 16'd0; eOp[c] = 3'd0;
            evRet[c] = 1'b0; evAbt[c] = 1'b0;
        end
        t  = 0;
        hb = 1'b0;
        clearNow();
        idleCycles(1);
        addT0 = t; issue(16'h1A23, 16'h0005, 16'h0007, 2, 16'h000C);
        movT0 = t; issue(16'h8450, 16'hBEEF, 16'h1111, 0, 16'h0);
        toT0  = t; issue(16'h3123, 16'h0001, 16'h0002, 0, 16'h0);
        exT0  = t; issue(16'h4B12, 16'h00AA, 16'h00BB, TMO, 16'h1234);
        idleCycles(2);
        clrT0 = t; issue(16'h5C34, 16'h0101, 16'h0202, 0, 16'h0);
        clearAt(clrT0 + 6);
        issue(16'h0000, 16'h0, 16'h0, 0, 16'h0);
        haltT0 = t; issue(16'hF000, 16'h0, 16'h0, 0, 16'h0);
        idleCycles(5);
        clearNow();
        postClrT = t;
        issue(16'h0000, 16'h0, 16'h0, 0, 16'h0);
        issue(16'h0123, 16'h0, 16'h0, 0, 16'h0);
        issue(16'h0FFF, 16'h0, 16'h0, 0, 16'h0);
        issue(16'h1A23, 16'h0005, 16'h0007, 2, 16'h000C);
        perfRetT = t;
        issue(16'h2345, 16'h0003, 16'h0004, 0, 16'h0);
        perfAbtT = t;
        for (int n = 0; n < 70 && t < NC - 60; n++) begin
            logic [15:0] ins;
            int d;
            int t0;
            ins = 16'($urandom);
            ins[15:12] = 4'($urandom_range(0, 14));
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
            t0 = t;
            issue(ins, 16'($urandom), 16'($urandom), d, 16'($urandom));
            if (t - t0 > 2 && $urandom_range(0, 7) == 0)
                clearAt(int'($urandom_range(t0 + 1, t - 1)));
            idleCycles(int'($urandom_range(0, 2)));
        end
        idleCycles(3);
        tEnd = t;
    endtask

    initial begin
        logic [15:0] expRet;
        logic [7:0]  expAbt;
        plan();
        expRet = 16'd0;
        expAbt = 8'd0;
        for (int c = 0; c < tEnd; c++) begin
            @(posedge clk);
            #1;
            clear       = vClear[c];
            instr_valid = vValid[c];
            instr       = vInstr[c];
            rf_a        = vRfA[c];
            rf_b        = vRfB[c];
            alu_done    = vDone[c];
            alu_result  = vRes[c];
            @(negedge clk);
            if (c > 0) begin
                chk("instr_ready", c, 32'(instr_ready), 32'(eReady[c]));
                chk("rf_load",     c, 32'(rf_load),     32'(eLoad[c]));
                chk("alu_start",   c, 32'(alu_start),   32'(eStart[c]));
                chk("err",         c, 32'(err),         32'(eErr[c]));
                chk("halted",      c, 32'(halted),      32'(eHalted[c]));
                if (chkRd[c]) begin
                    chk("rf_aaddr", c, 32'(rf_aaddr), 32'(eA[c]));
                    chk("rf_baddr", c, 32'(rf_baddr), 32'(eB[c]));
                end
                if (chkWr[c]) begin
                    chk("rf_caddr", c, 32'(rf_caddr), 32'(eCa[c]));
                    chk("rf_c",     c, 32'(rf_c),     32'(eC[c]));
                end
                if (eStart[c]) begin
                    chk("alu_opa", c, 32'(alu_opa), 32'(eOpa[c]));
                    chk("alu_opb", c, 32'(alu_opb), 32'(eOpb[c]));
                    chk("alu_op",  c, 32'(alu_op),  32'(eOp[c]));
                end
`ifdef RFC_PERF_CNT_EN
                chk("retired", c, 32'(retired), 32'(expRet));
                chk("aborted", c, 32'(aborted), 32'(expAbt));
`endif
            end
            // Hand-computed pins from the timing rules
            if (c == 1) begin
                chk("rst_aaddr", c, 32'(rf_aaddr), 32'h0);
                chk("rst_caddr", c, 32'(rf_caddr), 32'h0);
                chk("rst_rf_c",  c, 32'(rf_c),     32'h0);
                chk("rst_opa",   c, 32'(alu_opa),  32'h0);
                chk("rst_ready", c, 32'(instr_ready), 32'h1);
            end
            if (c == addT0 + 1) begin
                chk("add_load_a", c, 32'(rf_aaddr), 32'h2);
                chk("add_load_b", c, 32'(rf_baddr), 32'h3);
            end
            if (c == addT0 + 3) chk("add_start", c, 32'(alu_start), 32'h1);
            if (c == addT0 + 6) begin
                chk("add_wr_load", c, 32'(rf_load),  32'h1);
                chk("add_wr_addr", c, 32'(rf_caddr), 32'hA);
                chk("add_wr_data", c, 32'(rf_c),     32'h000C);
            end
            if (c == addT0 + 7) chk("add_ready", c, 32'(instr_ready), 32'h1);
            if (c == movT0 + 3) begin
                chk("mov_wr_data", c, 32'(rf_c),      32'hBEEF);
                chk("mov_wr_addr", c, 32'(rf_caddr),  32'h4);
                chk("mov_nostart", c, 32'(alu_start), 32'h0);
            end
            if (c == toT0 + 19) chk("to_err",   c, 32'(err),         32'h1);
            if (c == toT0 + 20) chk("to_ready", c, 32'(instr_ready), 32'h1);
            if (c == exT0 + 19) chk("ex_noerr", c, 32'(err),         32'h0);
            if (c == exT0 + 20) chk("ex_write", c, 32'(rf_c),        32'h1234);
            if (c == clrT0 + 7) chk("clr_ready", c, 32'(instr_ready), 32'h1);
            if (c == haltT0 + 1) begin
                chk("halt_set",   c, 32'(halted),      32'h1);
                chk("halt_ready", c, 32'(instr_ready), 32'h0);
            end
            if (c == postClrT) chk("unhalt", c, 32'(halted), 32'h0);
`ifdef RFC_PERF_CNT_EN
            if (c == perfRetT) chk("perf_retired", c, 32'(retired), 32'd4);
            if (c == perfAbtT) chk("perf_aborted", c, 32'(aborted), 32'd1);
`endif
            if (vClear[c]) begin
                expRet = 16'd0;
                expAbt = 8'd0;
            end else begin
                if (evRet[c]) expRet = expRet + 16'd1;
                if (evAbt[c] && expAbt != 8'hFF) expAbt = expAbt + 8'd1;
            end
            $display("cycle %0d: ready=%0b load=%0b start=%0b err=%0b halted=%0b",
                     c, instr_ready, rf_load, alu_start, err, halted);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Sequencer that drives the 16×16 register file's access ports on behalf of an instruction stream. It accepts 16-bit instructions over a valid/ready handshake and issues the register-file read of both source operands. It hands the operands to the ALU with a start/done handshake, then issues the write-back to the destination register. It sits between the instruction fetch path and the register file / ALU pair, acting as the initiator of every register-file read and write.

## Interface
- TIMEOUT, 16: max EXEC wait cycles for alu_done before abort.
- clk  in  1  clock; all state changes on rising edge.
- clear  in  1  synchronous, active-high reset.
- instr  in  16  instruction: [15:12] opcode, [11:8] dest, [7:4] srcA, [3:0] srcB.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  controller can accept; instr transfers when valid & ready.
- rf_aaddr, rf_baddr, rf_caddr  out  4 each  register-file A/B read and C write addresses.
- rf_c  out  16  write-back data.
- rf_load  out  1  register-file access strobe (read in READ, write in WRITE).
- rf_a, rf_b  in  16 each  register-file read data; valid the cycle after a READ strobe.
- alu_op  out  3  ALU operation = opcode[2:0].
- alu_opa, alu_opb  out  16 each  latched operands.
- alu_start  out  1  one-cycle start pulse.
- alu_done  in  1  ALU result valid on alu_result.
- alu_result  in  16  ALU result.
- err  out  1  one-cycle pulse on ALU timeout.
- halted  out  1  HALT executed; sticky until clear.

## Operation
- Opcodes:
  - 0x0 NOP.
  - 0x1–0x7 ALU ops.
  - 0x8 MOV (dest ← srcA, no ALU).
  - 0xF HALT.
  - All others are treated as NOP.
- States:
  - IDLE → on accept: NOP→IDLE, HALT→HALTED, else READ.
  - READ: rf_load=1, rf_aaddr=srcA, rf_baddr=srcB; → CAPTURE.
  - CAPTURE: latch rf_a→alu_opa, rf_b→alu_opb; MOV→WRITE with rf_c=rf_a, else → EXEC.
  - EXEC: alu_start=1 in the first EXEC cycle only; wait for alu_done (sampled from the cycle after start); latch alu_result → WRITE.
  - WRITE: rf_load=1, rf_caddr=dest, rf_c=result; → IDLE.
  - HALTED: instr_ready=0, halted=1; exit only via clear.
- instr_ready = (state==IDLE) & ~clear. Instruction fields are registered on accept; instr may change afterwards.
- Timeout: wait counter (5 bits) counts EXEC cycles after start. When it reaches TIMEOUT without done: err pulse, → IDLE, no WRITE.
- alu_done in the same cycle as timeout: done wins, no err.
- alu_done outside EXEC is ignored.
- Destination R0 is an ordinary register and is written.
- Reset values: state IDLE, rf_load 0, alu_start 0, err 0, halted 0, all address/data outputs 0, counter 0.
- clear mid-operation: abort immediately. No rf_load or alu_start in the cycle after clear, and any in-flight write is dropped.

## Timing
- Accept at cycle 0.
- READ is cycle 1, CAPTURE is cycle 2, EXEC starts at cycle 3 (alu_start).
- If alu_done arrives in cycle n ≥ 4, WRITE is at n+1 and IDLE (ready) at n+2.
- MOV: WRITE in cycle 3, ready in cycle 4.
- NOP: ready again in cycle 1, one instruction per 1 cycle.
- No overlap: at most one instruction in flight.

## Configuration
- RFC_PERF_CNT_EN defined:
  - Adds output retired (16 bits). It increments on each completed WRITE, NOP or HALT accept, and wraps at 0xFFFF→0.
  - Adds output aborted (8 bits). It increments on each timeout and saturates at 0xFF.
  - Both counters clear on clear.
- RFC_PERF_CNT_EN undefined: neither port nor its counter exists.

## Structure
- Package regfile_ctrl_pkg holds:
  - opcode constants (OP_NOP, OP_MOV, OP_HALT);
  - instruction field bit positions;
  - state enum (IDLE, READ, CAPTURE, EXEC, WRITE, HALTED);
  - default TIMEOUT.
- Sub-module rfc_decode: combinational opcode → {is_nop, is_alu, is_mov, is_halt, alu_op}.

## Test plan
- ADD 0x1A23, rf_a=0x0005, rf_b=0x0007, ALU done 2 cycles after start with 0x000C:
  - rf_load in cycle 1 with A=2, B=3; alu_start in cycle 3.
  - WRITE in cycle 6 with caddr=0xA, rf_c=0x000C; ready in cycle 7.
- MOV 0x8450, rf_a=0xBEEF: no alu_start; WRITE in cycle 3 with caddr=4, rf_c=0xBEEF.
- ALU op with alu_done never asserted: err pulses once after 16 EXEC cycles; no WRITE rf_load; ready next cycle.
- alu_done on the exact timeout cycle: WRITE occurs and err stays 0.
- clear asserted during EXEC, then NOP and HALT 0xF000: after clear, ready=1 and no stray rf_load. HALT sets halted=1 and ready=0 until the next clear.
- With RFC_PERF_CNT_EN: 3 NOPs + 1 ADD give retired=4, and one timeout gives aborted=1.
